// File: rtl/sixteen_bit_sequential_divider_if.sv
// Operand/result handshake bundle for the sequential divider.
// The master side presents operands and drains results; the slave side is the divider.
interface sixteen_bit_sequential_divider_if #(
    parameter int unsigned DIVIDEND_W = 16,
    parameter int unsigned DIVISOR_W  = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DIVIDEND_W-1:0] in1;
    logic [DIVISOR_W-1:0]  in2;
    logic                  out_valid;
    logic                  out_ready;
    logic [DIVIDEND_W-1:0] out;
    logic [DIVISOR_W-1:0]  rem;
    logic                  div_by_zero;

    modport master (
        output in_valid, in1, in2, out_ready,
        input  in_ready, out_valid, out, rem, div_by_zero
    );

    modport slave (
        input  in_valid, in1, in2, out_ready,
        output in_ready, out_valid, out, rem, div_by_zero
    );
endinterface

// File: rtl/sixteen_bit_sequential_divider.sv
// Iterative restoring divider: one quotient bit per clock, unsigned dividend / divisor.
// Divide by zero yields all-ones quotient and remainder with div_by_zero set.
module sixteen_bit_sequential_divider #(
    parameter int unsigned DIVIDEND_W = 16,
    parameter int unsigned DIVISOR_W  = 8
) (
    input logic clk,
    input logic rst_n,
    sixteen_bit_sequential_divider_if.slave bus
);
    localparam int unsigned CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVIDEND_W - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                state, state_next;
    logic [DIVIDEND_W-1:0] dividend;
    logic [DIVISOR_W-1:0]  divisor;
    logic [DIVISOR_W-1:0]  partial;
    logic [CNT_W-1:0]      count;
    logic                  ready_q;
    logic [DIVIDEND_W-1:0] quot_q;
    logic [DIVISOR_W-1:0]  rem_q;
    logic                  dbz_q;

    logic                  accept;
    logic [DIVISOR_W:0]    shifted;
    logic [DIVISOR_W:0]    diff;
    logic                  q_bit;
    logic [DIVISOR_W-1:0]  partial_next;
    logic [DIVIDEND_W-1:0] dividend_next;

    // The restored remainder is always below the divisor, so only the shifted
    // working value needs the extra bit; the borrow out of the trial subtract
    // decides the quotient bit.
    always_comb begin
        accept        = (state == IDLE) && ready_q && bus.in_valid;
        shifted       = {partial, dividend[DIVIDEND_W-1]};
        diff          = shifted - {1'b0, divisor};
        q_bit         = ~diff[DIVISOR_W];
        partial_next  = q_bit ? diff[DIVISOR_W-1:0] : shifted[DIVISOR_W-1:0];
        dividend_next = {dividend[DIVIDEND_W-2:0], q_bit};
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = (bus.in2 == '0) ? DONE : BUSY;
            BUSY: if (count == LAST) state_next = DONE;
            DONE: if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ready_q  <= 1'b0;
            dividend <= '0;
            divisor  <= '0;
            partial  <= '0;
            count    <= '0;
            quot_q   <= '0;
            rem_q    <= '0;
            dbz_q    <= 1'b0;
        end else begin
            ready_q <= (state_next == IDLE);
            if (accept) begin
                dividend <= bus.in1;
                divisor  <= bus.in2;
                partial  <= '0;
                count    <= '0;
                if (bus.in2 == '0) begin
                    quot_q <= '1;
                    rem_q  <= '1;
                    dbz_q  <= 1'b1;
                end
            end else if (state == BUSY) begin
                dividend <= dividend_next;
                partial  <= partial_next;
                count    <= count + 1'b1;
                if (count == LAST) begin
                    quot_q <= dividend_next;
                    rem_q  <= partial_next;
                    dbz_q  <= 1'b0;
                end
            end
        end
    end

    assign bus.in_ready    = ready_q;
    assign bus.out_valid   = (state == DONE);
    assign bus.out         = quot_q;
    assign bus.rem         = rem_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_sixteen_bit_sequential_divider.sv
// Directed and randomized checks of the sequential divider through its handshake interface.
module tb_sixteen_bit_sequential_divider;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    sixteen_bit_sequential_divider_if #(.DIVIDEND_W(16), .DIVISOR_W(8)) bus ();

    sixteen_bit_sequential_divider #(.DIVIDEND_W(16), .DIVISOR_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Presents one operand pair and waits for the result; lat counts edges including the accepting one.
    task automatic run_op(input logic [15:0] a, input logic [7:0] b,
                          output logic [15:0] q, output logic [7:0] r, output logic z,
                          output int lat, output bit ok);
        lat = 0;
        wait_ready(ok);
        if (!ok) return;
        bus.in_valid = 1'b1;
        bus.in1 = a;
        bus.in2 = b;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        ok = bus.out_valid;
        q = bus.out;
        r = bus.rem;
        z = bus.div_by_zero;
    endtask

    task automatic handoff(input int hold);
        repeat (hold) @(negedge clk);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.in1 = '0;
        bus.in2 = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.out, bus.rem, bus.div_by_zero} !== 27'd0) begin
            failures++;
            $display("FAIL reset_outputs got rdy=%b vld=%b out=%h rem=%h dbz=%b exp all zero",
                     bus.in_ready, bus.out_valid, bus.out, bus.rem, bus.div_by_zero);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_ready got=%b exp=0", bus.in_ready);
        end
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_release got=%b exp=1", bus.in_ready);
        end
    endtask

    task automatic test_basic();
        logic [15:0] q;
        logic [7:0]  r;
        logic        z;
        int          lat;
        bit          ok;
        run_op(16'd65025, 8'd255, q, r, z, lat, ok);
        checks++;
        if (!ok || lat !== 17) begin
            failures++;
            $display("FAIL basic_latency got=%0d ok=%0d exp=17", lat, ok);
        end
        checks++;
        if ({q, r, z} !== {16'd255, 8'd0, 1'b0}) begin
            failures++;
            $display("FAIL basic_65025_255 got q=%0d r=%0d z=%b exp q=255 r=0 z=0", q, r, z);
        end
        handoff(0);
        run_op(16'd1000, 8'd7, q, r, z, lat, ok);
        checks++;
        if (!ok || {q, r, z} !== {16'd142, 8'd6, 1'b0}) begin
            failures++;
            $display("FAIL basic_1000_7 got q=%0d r=%0d z=%b ok=%0d exp q=142 r=6 z=0", q, r, z, ok);
        end
        handoff(1);
    endtask

    task automatic test_div_by_zero();
        logic [15:0] q;
        logic [7:0]  r;
        logic        z;
        int          lat;
        bit          ok;
        run_op(16'd1234, 8'd0, q, r, z, lat, ok);
        checks++;
        if (!ok || lat !== 1) begin
            failures++;
            $display("FAIL dbz_latency got=%0d ok=%0d exp=1", lat, ok);
        end
        checks++;
        if ({q, r, z} !== {16'hFFFF, 8'hFF, 1'b1}) begin
            failures++;
            $display("FAIL dbz_result got q=%h r=%h z=%b exp q=ffff r=ff z=1", q, r, z);
        end
        handoff(0);
    endtask

    task automatic test_hold();
        logic [15:0] q;
        logic [7:0]  r;
        logic        z;
        int          lat;
        bit          ok;
        int          bad;
        run_op(16'd1000, 8'd7, q, r, z, lat, ok);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!bus.out_valid || bus.in_ready || bus.out !== 16'd142 || bus.rem !== 8'd6 || bus.div_by_zero)
                bad++;
        end
        checks++;
        if (!ok || bad !== 0) begin
            failures++;
            $display("FAIL hold_stable got bad_cycles=%0d ok=%0d exp bad_cycles=0", bad, ok);
        end
        handoff(0);
        checks++;
        if ({bus.out_valid, bus.in_ready, bus.out, bus.rem} !== {1'b0, 1'b1, 16'd142, 8'd6}) begin
            failures++;
            $display("FAIL after_handoff got vld=%b rdy=%b out=%0d rem=%0d exp vld=0 rdy=1 out=142 rem=6",
                     bus.out_valid, bus.in_ready, bus.out, bus.rem);
        end
    endtask

    task automatic test_busy_ignore();
        bit ok;
        int lat;
        int busy_ready;
        wait_ready(ok);
        bus.in_valid = 1'b1;
        bus.in1 = 16'd5000;
        bus.in2 = 8'd3;
        @(posedge clk);
        lat = 1;
        busy_ready = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (bus.in_ready) busy_ready++;
            bus.in_valid = i[0];
            bus.in1 = 16'(i * 977 + 3);
            bus.in2 = 8'(i);
            @(posedge clk);
            lat++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++;
        if (busy_ready !== 0) begin
            failures++;
            $display("FAIL busy_in_ready got=%0d cycles high exp=0", busy_ready);
        end
        checks++;
        if (!ok || !bus.out_valid || lat !== 17 || bus.out !== 16'd1666 || bus.rem !== 8'd2) begin
            failures++;
            $display("FAIL busy_ignore got vld=%b lat=%0d q=%0d r=%0d exp vld=1 lat=17 q=1666 r=2",
                     bus.out_valid, lat, bus.out, bus.rem);
        end
        handoff(0);
    endtask

    task automatic test_back_to_back();
        logic [15:0] q;
        logic [7:0]  r;
        logic        z;
        int          lat;
        bit          ok;
        run_op(16'd65025, 8'd255, q, r, z, lat, ok);
        // Offer new operands on the handoff edge; they must wait for the IDLE cycle.
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.in1 = 16'hFFFF;
        bus.in2 = 8'd1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        checks++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
            failures++;
            $display("FAIL b2b_idle_cycle got vld=%b rdy=%b exp vld=0 rdy=1", bus.out_valid, bus.in_ready);
        end
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        checks++;
        if (!ok || lat !== 17 || {bus.out, bus.rem, bus.div_by_zero} !== {16'hFFFF, 8'd0, 1'b0}) begin
            failures++;
            $display("FAIL b2b_ffff_1 got lat=%0d q=%h r=%0d z=%b exp lat=17 q=ffff r=0 z=0",
                     lat, bus.out, bus.rem, bus.div_by_zero);
        end
        handoff(0);
    endtask

    task automatic test_reset_abort();
        logic [15:0] q;
        logic [7:0]  r;
        logic        z;
        int          lat;
        bit          ok;
        bit          seen;
        wait_ready(ok);
        bus.in_valid = 1'b1;
        bus.in1 = 16'd40000;
        bus.in2 = 8'd200;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (bus.out_valid) seen = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (seen !== 1'b0 || {bus.out, bus.rem, bus.div_by_zero} !== 25'd0) begin
            failures++;
            $display("FAIL reset_abort got seen_valid=%b out=%0d rem=%0d dbz=%b exp 0 0 0 0",
                     seen, bus.out, bus.rem, bus.div_by_zero);
        end
        run_op(16'd100, 8'd9, q, r, z, lat, ok);
        checks++;
        if (!ok || {q, r, z} !== {16'd11, 8'd1, 1'b0}) begin
            failures++;
            $display("FAIL after_abort_100_9 got q=%0d r=%0d z=%b ok=%0d exp q=11 r=1 z=0", q, r, z, ok);
        end
        handoff(0);
    endtask

    task automatic test_sweep();
        logic [15:0] q, a;
        logic [7:0]  r, b;
        logic        z;
        int          lat;
        bit          ok;
        int unsigned prod;
        for (int i = 0; i < 1000; i++) begin
            a = 16'($urandom);
            b = (i % 50 == 7) ? 8'd0 : 8'($urandom);
            run_op(a, b, q, r, z, lat, ok);
            checks++;
            if (b == 8'd0) begin
                if (!ok || lat !== 1 || {q, r, z} !== {16'hFFFF, 8'hFF, 1'b1}) begin
                    failures++;
                    $display("FAIL sweep_dbz a=%0d got q=%h r=%h z=%b lat=%0d exp ffff ff 1 lat=1", a, q, r, z, lat);
                end
            end else begin
                prod = 32'(q) * 32'(b) + 32'(r);
                if (!ok || lat !== 17 || prod !== 32'(a) || r >= b || z !== 1'b0) begin
                    failures++;
                    $display("FAIL sweep a=%0d b=%0d got q=%0d r=%0d z=%b lat=%0d exp q*b+r=a r<b z=0 lat=17",
                             a, b, q, r, z, lat);
                end
            end
            handoff($urandom_range(0, 3));
        end
        for (int i = 0; i < 50; i++) begin
            a = 16'($urandom_range(0, 255));
            b = 8'($urandom_range(1, 255));
            run_op(16'(a * b), b, q, r, z, lat, ok);
            checks++;
            if (!ok || q !== a || r !== 8'd0 || z !== 1'b0) begin
                failures++;
                $display("FAIL product_xcheck a=%0d b=%0d got q=%0d r=%0d z=%b exp q=%0d r=0 z=0", a, b, q, r, z, a);
            end
            handoff($urandom_range(0, 2));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_by_zero();
        test_hold();
        test_busy_ignore();
        test_back_to_back();
        test_reset_abort();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
